instr_encoder_loader: RTL and testbench

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

---
 rtl/rv_enc_pkg.sv | 41 ++++
 rtl/rv_instr_pack.sv | 57 +++++
 rtl/instr_encoder_loader.sv | 129 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg: op codes, RV32I field constants, NOP and loader FSM states
package rv_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLT, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_ORI, OP_ANDI,
        OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_JALR, OP_RSVD
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // R-type and I-ALU ops share funct3 per operation
    function automatic logic [2:0] alu_f3(input op_e op);
        return (op == OP_SLT || op == OP_SLTI) ? F3_SLT :
               (op == OP_OR  || op == OP_ORI)  ? F3_OR  :
               (op == OP_AND || op == OP_ANDI) ? F3_AND : F3_ADD;
    endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// rv_instr_pack: combinational RV32I encoder with illegal-descriptor flag
module rv_instr_pack
    import rv_enc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    op_e                opc;
    logic signed [31:0] simm;
    logic               i_bad, b_bad, j_bad;

    assign opc   = op_e'(op);
    assign simm  = imm;
    assign i_bad = simm < -32'sd2048 || simm > 32'sd2047;
    assign b_bad = simm < -32'sd4096 || simm > 32'sd4094 || imm[0];
    assign j_bad = simm < -32'sd1048576 || simm > 32'sd1048574 || imm[0];

    always_comb begin
        word    = NOP;
        illegal = 1'b0;
        case (opc)
            OP_ADD, OP_SUB, OP_SLT, OP_OR, OP_AND:
                word = {((opc == OP_SUB) ? F7_SUB : F7_BASE), rs2, rs1, alu_f3(opc), rd, OPC_R};
            OP_ADDI, OP_SLTI, OP_ORI, OP_ANDI: begin
                word    = {imm[11:0], rs1, alu_f3(opc), rd, OPC_I};
                illegal = i_bad;
            end
            OP_LW: begin
                word    = {imm[11:0], rs1, F3_W, rd, OPC_LOAD};
                illegal = i_bad;
            end
            OP_SW: begin
                word    = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
                illegal = i_bad;
            end
            OP_BEQ, OP_BNE: begin
                word    = {imm[12], imm[10:5], rs2, rs1, ((opc == OP_BEQ) ? F3_BEQ : F3_BNE),
                           imm[4:1], imm[11], OPC_BRANCH};
                illegal = b_bad;
            end
            OP_JAL: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                illegal = j_bad;
            end
            OP_JALR: begin
                word    = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
                illegal = i_bad;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes descriptors and writes them to imem; ENC_ILLEGAL_CHECK_EN adds sticky err and NOPs illegal ones
module instr_encoder_loader
    import rv_enc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] count
`ifdef ENC_ILLEGAL_CHECK_EN
    ,
    output logic        err
`endif
);
`ifdef ENC_ILLEGAL_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
    logic err_q, err_d;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic [15:0] count_q, count_d;
    logic        last_q, last_d;
    logic [31:0] pack_word;
    logic        pack_illegal;

    rv_instr_pack u_pack (
        .op      (in_op),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        word_d   = word_q;
        count_d  = count_q;
        last_d   = last_q;
`ifdef ENC_ILLEGAL_CHECK_EN
        err_d    = err_q;
`endif
        in_ready = 1'b0;
        imem_we  = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: if (load_start) begin
                state_d = S_ACCEPT;
                addr_d  = base_addr;
                count_d = '0;
`ifdef ENC_ILLEGAL_CHECK_EN
                err_d   = 1'b0;
`endif
            end
            S_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_WRITE;
                    word_d  = (CHECK_EN && pack_illegal) ? NOP : pack_word;
                    last_d  = in_last;
`ifdef ENC_ILLEGAL_CHECK_EN
                    err_d   = err_q | pack_illegal;
`endif
                end
            end
            S_WRITE: begin
                // a reset landing on the write cycle must not leak a strobe
                imem_we = !reset;
                addr_d  = addr_q + 32'd4;
                count_d = count_q + 16'd1;
                state_d = last_q ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            count_q <= count_d;
            last_q  <= last_d;
`ifdef ENC_ILLEGAL_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign count      = count_q;
    assign busy       = state_q != S_IDLE;
`ifdef ENC_ILLEGAL_CHECK_EN
    assign err        = err_q;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: table-driven encode vectors plus multi-cycle session sequences
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        busy, done;
    logic [15:0] count;
`ifdef ENC_ILLEGAL_CHECK_EN
    logic        err;
    localparam logic [31:0] ADDI_BIG_EXP = 32'h0000_0013;
`else
    localparam logic [31:0] ADDI_BIG_EXP = 32'h0000_0093;
`endif

    int vecs = 0;
    int errs = 0;

    instr_encoder_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .count      (count)
`ifdef ENC_ILLEGAL_CHECK_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] b);
        load_start = 1'b1;
        base_addr  = b;
        tick();
        load_start = 1'b0;
        chk("ready_after_start", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input string tag, input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic last, input logic [31:0] exp_word, input logic [31:0] exp_addr);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_last  = last;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_we"}, 32'(imem_we), 32'd1);
        chk({tag, "_word"}, imem_wdata, exp_word);
        chk({tag, "_addr"}, imem_addr, exp_addr);
        chk({tag, "_ready_in_write"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, "_we_after"}, 32'(imem_we), 32'd0);
    endtask

    task automatic finish_session(input string tag, input logic [15:0] exp_cnt, input logic [31:0] exp_addr);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
        chk({tag, "_final_addr"}, imem_addr, exp_addr);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_count_hold"}, 32'(count), 32'(exp_cnt));
        chk({tag, "_addr_hold"}, imem_addr, exp_addr);
    endtask

    initial begin
        vt[0]  = '{4'd0,  5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3};
        vt[1]  = '{4'd1,  5'd5, 5'd6, 5'd7, 32'd0,          32'h407302B3};
        vt[2]  = '{4'd5,  5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093};
        vt[3]  = '{4'd9,  5'd2, 5'd1, 5'd0, 32'd8,          32'h0080A103};
        vt[4]  = '{4'd10, 5'd0, 5'd1, 5'd2, 32'd12,         32'h0020A623};
        vt[5]  = '{4'd11, 5'd0, 5'd1, 5'd2, 32'd8,          32'h00208463};
        vt[6]  = '{4'd13, 5'd1, 5'd0, 5'd0, 32'd16,         32'h010000EF};
        vt[7]  = '{4'd15, 5'd1, 5'd2, 5'd3, 32'd0,          32'h00000013};
        vt[8]  = '{4'd2,  5'd4, 5'd5, 5'd6, 32'd0,          32'h0062A233};
        vt[9]  = '{4'd3,  5'd1, 5'd2, 5'd3, 32'd0,          32'h003160B3};
        vt[10] = '{4'd4,  5'd1, 5'd2, 5'd3, 32'd0,          32'h003170B3};
        vt[11] = '{4'd6,  5'd1, 5'd2, 5'd0, 32'hFFFFFFFF,   32'hFFF12093};
        vt[12] = '{4'd7,  5'd1, 5'd2, 5'd0, 32'h000007FF,   32'h7FF16093};
        vt[13] = '{4'd8,  5'd3, 5'd3, 5'd0, 32'h000000FF,   32'h0FF1F193};
        vt[14] = '{4'd12, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE209EE3};
        vt[15] = '{4'd14, 5'd1, 5'd2, 5'd0, 32'd4,          32'h004100E7};
        vt[16] = '{4'd13, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8,   32'hFF9FF06F};
        vt[17] = '{4'd5,  5'd1, 5'd0, 5'd0, 32'd4096,       ADDI_BIG_EXP};

        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 18; i++) begin
            logic [31:0] b;
            b = 32'h100 + 32'(i) * 32'h10;
            start(b);
            send($sformatf("vec%0d", i), vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm,
                 1'b1, vt[i].exp, b);
            finish_session($sformatf("vec%0d", i), 16'd1, b + 32'd4);
        end

        start(32'h0);
        send("s4_sub",  4'd1,  5'd5, 5'd6, 5'd7, 32'd0,  1'b0, 32'h407302B3, 32'h0);
        send("s4_addi", 4'd5,  5'd1, 5'd0, 5'd0, 32'd5,  1'b0, 32'h00500093, 32'h4);
        send("s4_lw",   4'd9,  5'd2, 5'd1, 5'd0, 32'd8,  1'b0, 32'h0080A103, 32'h8);
        send("s4_sw",   4'd10, 5'd0, 5'd1, 5'd2, 32'd12, 1'b1, 32'h0020A623, 32'hC);
        finish_session("s4", 16'd4, 32'h10);

        start(32'hFFFFFFFC);
        send("wrap0", 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3, 32'hFFFFFFFC);
        send("wrap1", 4'd3, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h003160B3, 32'h0);
        finish_session("wrap", 16'd2, 32'h4);

        start(32'h200);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                load_start = 1'b1;
                base_addr  = 32'h999;
            end
            tick();
            load_start = 1'b0;
            chk("stall_we", 32'(imem_we), 32'd0);
            chk("stall_ready", 32'(in_ready), 32'd1);
            chk("stall_addr", imem_addr, 32'h200);
        end
        send("stall", 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 32'h200);
        finish_session("stall", 16'd1, 32'h204);

        start(32'h300);
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_rd    = 5'd3;
        in_rs1   = 5'd1;
        in_rs2   = 5'd2;
        in_imm   = 32'd0;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("prereset_we", 32'(imem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_write_we", 32'(imem_we), 32'd0);
        tick();
        reset = 1'b0;
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_addr", imem_addr, 32'd0);
        chk("post_reset_wdata", imem_wdata, 32'd0);
        chk("post_reset_count", 32'(count), 32'd0);
        tick();
        chk("post_reset_we", 32'(imem_we), 32'd0);
        chk("post_reset_done", 32'(done), 32'd0);

`ifdef ENC_ILLEGAL_CHECK_EN
        start(32'h400);
        chk("err_clear_start", 32'(err), 32'd0);
        send("err_addi", 4'd5, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, 32'h00000013, 32'h400);
        chk("err_set", 32'(err), 32'd1);
        finish_session("err_addi", 16'd1, 32'h404);
        chk("err_sticky_idle", 32'(err), 32'd1);
        start(32'h500);
        chk("err_cleared", 32'(err), 32'd0);
        send("err_beq_odd", 4'd11, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1, 32'h00000013, 32'h500);
        chk("err_beq_odd", 32'(err), 32'd1);
        finish_session("err_beq", 16'd1, 32'h504);
        start(32'h600);
        send("ok_addi", 4'd5, 5'd1, 5'd0, 5'd0, 32'd2047, 1'b1, 32'h7FF00093, 32'h600);
        chk("err_legal", 32'(err), 32'd0);
        finish_session("ok_addi", 16'd1, 32'h604);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
